// File: rtl/frontend_cmd_issuer_pkg.sv
// Shared command types for the frontend<->backend command interface.
`ifndef DQ_BITS
`define DQ_BITS 16
`endif
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 25
`endif

package frontend_command_definition_pkg;

    localparam int unsigned ROW_W  = 14;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned DATA_W = `DQ_BITS * 8;
    localparam int unsigned CMD_W  = `FRONTEND_CMD_BITS;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_type_e;

    typedef struct packed {
        op_type_e           op_type;
        logic [ROW_W-1:0]   row_addr;
        logic [COL_W-1:0]   col_addr;
    } frontend_command_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } ISSUER_FSM_e;

endpackage

// File: rtl/frontend_cmd_issuer_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; also exposes the entry behind the head.
module issuer_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [WIDTH-1:0]         o_rdata_next,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;
    logic [AW-1:0]      w_rd_idx_next;

    assign o_empty       = (r_wr_ptr == r_rd_ptr);
    assign o_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count       = r_wr_ptr - r_rd_ptr;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_push        = i_push && (!o_full || i_pop);
    assign w_pop         = i_pop && !o_empty;
    assign w_rd_idx_next = r_rd_ptr[AW-1:0] + AW'(1);
    assign o_rdata       = r_mem[r_rd_ptr[AW-1:0]];
    assign o_rdata_next  = r_mem[w_rd_idx_next];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/frontend_cmd_issuer.sv
// Frontend command issuer: queues user requests, issues them to the backend, buffers read returns.
// Optional performance counters are enabled by defining ISSUER_PERF_CNT_EN.
module frontend_cmd_issuer
    import frontend_command_definition_pkg::*;
#(
    parameter int unsigned CMD_DEPTH    = 8,
    parameter int unsigned WDATA_DEPTH  = 8,
    parameter int unsigned RDATA_DEPTH  = 8,
    parameter int unsigned STALL_MARGIN = 2
) (
    input  logic                clk,
    input  logic                power_on_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_write,
    input  logic [ROW_W-1:0]    i_req_row,
    input  logic [COL_W-1:0]    i_req_col,
    input  logic [DATA_W-1:0]   i_req_wdata,
    output logic                o_resp_valid,
    input  logic                i_resp_ready,
    output logic [DATA_W-1:0]   o_resp_data,
    output logic                o_frontend_command_valid,
    output logic [CMD_W-1:0]    o_frontend_command,
    input  logic                i_backend_controller_ready,
    input  logic                i_backend_controller_ren,
    output logic [DATA_W-1:0]   o_frontend_write_data,
    input  logic                i_backend_read_data_valid,
    input  logic [DATA_W-1:0]   i_backend_read_data,
    output logic                o_backend_controller_stall,
    output logic                o_frontend_controller_ready,
    output logic                o_wdata_underflow
`ifdef ISSUER_PERF_CNT_EN
    ,
    output logic [31:0]         o_rd_issued_cnt,
    output logic [31:0]         o_wr_issued_cnt,
    output logic [31:0]         o_stall_cycles_cnt
`endif
);

    localparam int unsigned CC_W  = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned WC_W  = $clog2(WDATA_DEPTH) + 1;
    localparam int unsigned RC_W  = $clog2(RDATA_DEPTH) + 1;
    localparam int unsigned SUM_W = RC_W + 1;

    ISSUER_FSM_e        r_state;
    ISSUER_FSM_e        w_state_nxt;
    logic               r_ready_en;
    logic               r_stall;
    logic               r_underflow;
    logic [RC_W-1:0]    r_rd_out;
    logic [RC_W-1:0]    w_rd_out_nxt;

    frontend_command_t  w_cmd_in;
    frontend_command_t  w_cmd_head;
    frontend_command_t  w_cmd_next;
    logic               w_cmd_full;
    logic               w_cmd_empty;
    logic [CC_W-1:0]    w_cmd_count;
    logic               w_cmd_pop;

    logic [DATA_W-1:0]  w_wd_head;
    logic [DATA_W-1:0]  w_wd_next;
    logic               w_wd_full;
    logic               w_wd_empty;
    logic [WC_W-1:0]    w_wd_count;

    logic [DATA_W-1:0]  w_rq_head;
    logic [DATA_W-1:0]  w_rq_next;
    logic               w_rq_full;
    logic               w_rq_empty;
    logic [RC_W-1:0]    w_rq_count;
    logic               w_rq_pop;
    logic               w_rq_push_act;
    logic [RC_W-1:0]    w_rq_free;
    logic [SUM_W-1:0]   w_rq_cnt_nxt;

    logic               w_req_ready;
    logic               w_req_fire;
    logic               w_rd_fire;
    logic               w_ret_dec;
    logic               w_credit_ok;
    logic               w_credit_nxt_ok;
    logic               w_unused;

    assign w_req_ready = r_ready_en && !w_cmd_full && (!i_req_write || !w_wd_full);
    assign w_req_fire  = i_req_valid && w_req_ready;
    assign w_cmd_in    = '{op_type: (i_req_write ? OP_WRITE : OP_READ), row_addr: i_req_row, col_addr: i_req_col};

    issuer_sync_fifo #(.WIDTH($bits(frontend_command_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk          (clk),
        .rst_n        (power_on_rst_n),
        .i_push       (w_req_fire),
        .i_wdata      (w_cmd_in),
        .i_pop        (w_cmd_pop),
        .o_rdata      (w_cmd_head),
        .o_rdata_next (w_cmd_next),
        .o_full       (w_cmd_full),
        .o_empty      (w_cmd_empty),
        .o_count      (w_cmd_count)
    );

    issuer_sync_fifo #(.WIDTH(DATA_W), .DEPTH(WDATA_DEPTH)) u_wdata_fifo (
        .clk          (clk),
        .rst_n        (power_on_rst_n),
        .i_push       (w_req_fire && i_req_write),
        .i_wdata      (i_req_wdata),
        .i_pop        (i_backend_controller_ren),
        .o_rdata      (w_wd_head),
        .o_rdata_next (w_wd_next),
        .o_full       (w_wd_full),
        .o_empty      (w_wd_empty),
        .o_count      (w_wd_count)
    );

    issuer_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RDATA_DEPTH)) u_rdata_fifo (
        .clk          (clk),
        .rst_n        (power_on_rst_n),
        .i_push       (i_backend_read_data_valid),
        .i_wdata      (i_backend_read_data),
        .i_pop        (w_rq_pop),
        .o_rdata      (w_rq_head),
        .o_rdata_next (w_rq_next),
        .o_full       (w_rq_full),
        .o_empty      (w_rq_empty),
        .o_count      (w_rq_count)
    );

    assign w_rq_pop      = !w_rq_empty && i_resp_ready;
    assign w_rq_push_act = i_backend_read_data_valid && (!w_rq_full || w_rq_pop);
    assign w_rq_free     = RC_W'(RDATA_DEPTH) - w_rq_count;
    assign w_rd_fire     = w_cmd_pop && (w_cmd_head.op_type == OP_READ);
    assign w_ret_dec     = i_backend_read_data_valid && (r_rd_out != '0);

    // Read credit now, and as it will stand after this cycle's handshake/return/pop.
    assign w_credit_ok     = (SUM_W'(r_rd_out) + SUM_W'(w_rq_count)) < SUM_W'(RDATA_DEPTH);
    assign w_rq_cnt_nxt    = SUM_W'(w_rq_count) + SUM_W'(w_rq_push_act) - SUM_W'(w_rq_pop);
    assign w_credit_nxt_ok = (SUM_W'(w_rd_out_nxt) + w_rq_cnt_nxt) < SUM_W'(RDATA_DEPTH);

    always_comb begin
        w_rd_out_nxt = r_rd_out;
        if (w_rd_fire && !w_ret_dec) begin
            w_rd_out_nxt = r_rd_out + RC_W'(1);
        end else if (!w_rd_fire && w_ret_dec) begin
            w_rd_out_nxt = r_rd_out - RC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            r_state     <= IDLE;
            r_ready_en  <= 1'b0;
            r_stall     <= 1'b0;
            r_underflow <= 1'b0;
            r_rd_out    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready_en  <= 1'b1;
            r_stall     <= (w_rq_free <= RC_W'(STALL_MARGIN));
            r_underflow <= r_underflow || (i_backend_controller_ren && w_wd_empty);
            r_rd_out    <= w_rd_out_nxt;
        end
    end

    // Issue FSM: stays in ISSUE across a handshake when the following entry is already eligible.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_pop   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_cmd_empty && (w_cmd_head.op_type == OP_WRITE || w_credit_ok)) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (i_backend_controller_ready) begin
                    w_cmd_pop = 1'b1;
                    if (w_cmd_count >= CC_W'(2) && (w_cmd_next.op_type == OP_WRITE || w_credit_nxt_ok)) begin
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_req_ready                 = w_req_ready;
    assign o_frontend_command_valid    = (r_state == ISSUE);
    assign o_frontend_command          = (r_state == ISSUE) ? CMD_W'(w_cmd_head) : '0;
    assign o_frontend_write_data       = w_wd_empty ? '0 : w_wd_head;
    assign o_resp_valid                = !w_rq_empty;
    assign o_resp_data                 = w_rq_empty ? '0 : w_rq_head;
    assign o_backend_controller_stall  = r_stall;
    assign o_frontend_controller_ready = r_ready_en;
    assign o_wdata_underflow           = r_underflow;
    assign w_unused                    = &{1'b0, w_wd_next, w_wd_count, w_rq_next};

`ifdef ISSUER_PERF_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating event counters.
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_rd_fire && r_rd_cnt != 32'hFFFF_FFFF) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_cmd_pop && !w_rd_fire && r_wr_cnt != 32'hFFFF_FFFF) r_wr_cnt <= r_wr_cnt + 32'd1;
            if (r_stall && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_rd_issued_cnt    = r_rd_cnt;
    assign o_wr_issued_cnt    = r_wr_cnt;
    assign o_stall_cycles_cnt = r_stall_cnt;
`endif

endmodule
